// File: rtl/coin_sense_encoder.sv
// Coin chute front end: synchronises and debounces the nickel/dime sensor lines and
// emits one-cycle coin codes or reject pulses, with saturating per-denomination counts.
module coin_sense_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RELEASE_CYCLES  = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             nickel_sense,
  input  logic             dime_sense,
  input  logic             inhibit,
  output logic [1:0]       coin,
  output logic             reject,
  output logic             busy,
  output logic [CNT_W-1:0] nickel_count,
  output logic [CNT_W-1:0] dime_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]    REL_LAST = RW'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    EMIT,
    REJECT,
    RELEASE
  } state_t;

  state_t state, next_state;

  logic [1:0]    n_sync, d_sync;
  logic          s_n, s_d;
  logic          den_dime, next_den_dime;
  logic [DW-1:0] deb_cnt, next_deb_cnt;
  logic [RW-1:0] rel_cnt, next_rel_cnt;
  logic          latched_line, other_line;

  // Two-flop synchronisers; only the second stage is ever observed.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_sync <= 2'b00;
      d_sync <= 2'b00;
    end else begin
      n_sync <= {n_sync[0], nickel_sense};
      d_sync <= {d_sync[0], dime_sense};
    end
  end

  assign s_n = n_sync[1];
  assign s_d = d_sync[1];

  assign latched_line = den_dime ? s_d : s_n;
  assign other_line   = den_dime ? s_n : s_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      den_dime <= 1'b0;
      deb_cnt  <= '0;
      rel_cnt  <= '0;
    end else begin
      state    <= next_state;
      den_dime <= next_den_dime;
      deb_cnt  <= next_deb_cnt;
      rel_cnt  <= next_rel_cnt;
    end
  end

  always_comb begin
    next_state    = state;
    next_den_dime = den_dime;
    next_deb_cnt  = deb_cnt;
    next_rel_cnt  = rel_cnt;
    unique case (state)
      IDLE: begin
        if (s_n && s_d) begin
          next_state = REJECT;
        end else if (s_n ^ s_d) begin
          next_state    = QUALIFY;
          next_den_dime = s_d;
          next_deb_cnt  = DW'(1);
        end
      end
      QUALIFY: begin
        if (s_n && s_d) begin
          next_state = REJECT;
        end else if (!latched_line && !other_line) begin
          next_state = IDLE;
        end else if (!latched_line) begin
          next_state = REJECT;
        end else if (deb_cnt == DEB_LAST) begin
          // inhibit only matters on this single decision edge
          next_state = inhibit ? REJECT : EMIT;
        end else begin
          next_deb_cnt = deb_cnt + DW'(1);
        end
      end
      EMIT, REJECT: begin
        next_state   = RELEASE;
        next_rel_cnt = '0;
      end
      RELEASE: begin
        // A coin still in the chute keeps us here, so it can never count twice
        if (s_n || s_d) begin
          next_rel_cnt = '0;
        end else if (rel_cnt == REL_LAST) begin
          next_state   = IDLE;
          next_rel_cnt = '0;
        end else begin
          next_rel_cnt = rel_cnt + RW'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs decoded from the next state, so pulses line up with EMIT/REJECT
  always_ff @(posedge clk) begin
    if (reset) begin
      coin         <= 2'b00;
      reject       <= 1'b0;
      nickel_count <= '0;
      dime_count   <= '0;
    end else begin
      coin   <= (next_state == EMIT) ? (next_den_dime ? 2'b10 : 2'b01) : 2'b00;
      reject <= (next_state == REJECT);
      if (next_state == EMIT) begin
        if (next_den_dime) begin
          if (dime_count != CNT_MAX) dime_count <= dime_count + CNT_W'(1);
        end else begin
          if (nickel_count != CNT_MAX) nickel_count <= nickel_count + CNT_W'(1);
        end
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_sense_encoder.sv
// Scoreboard bench for coin_sense_encoder: directed coin/glitch/reject sequences push
// expected pulses (with their exact cycle); a negedge monitor pops and compares.
module tb_coin_sense_encoder;

  logic       clk;
  logic       reset;
  logic       nickel_sense;
  logic       dime_sense;
  logic       inhibit;
  logic [1:0] coin;
  logic       reject;
  logic       busy;
  logic [7:0] nickel_count;
  logic [7:0] dime_count;

  typedef struct {
    logic [1:0] code;
    logic       rej;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   tests;
  int   failures;

  coin_sense_encoder #(
    .DEBOUNCE_CYCLES(4),
    .RELEASE_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .nickel_sense(nickel_sense),
    .dime_sense  (dime_sense),
    .inhibit     (inhibit),
    .coin        (coin),
    .reject      (reject),
    .busy        (busy),
    .nickel_count(nickel_count),
    .dime_count  (dime_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Latency is counted in edges after the first edge that samples the raw line high
  task automatic applyStimulus(input logic n, input logic d, input int hold, input logic inh,
                               input logic [1:0] exp_code, input logic exp_rej, input int lat);
    int waited;
    if (exp_code != 2'b00 || exp_rej) sb.push_back('{exp_code, exp_rej, cyc + 1 + lat});
    nickel_sense = n;
    dime_sense   = d;
    inhibit      = inh;
    repeat (hold) @(negedge clk);
    nickel_sense = 1'b0;
    dime_sense   = 1'b0;
    repeat (3) @(negedge clk);
    waited = 0;
    while (busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("idle_timeout", int'(busy), 0);
    inhibit = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && (coin != 2'b00 || reject)) begin
      tests++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pulse: got coin=%b reject=%b at cycle %0d, expected none",
                 coin, reject, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (coin !== e.code || reject !== e.rej || cyc != e.at) begin
          failures++;
          $display("[TB] FAIL pulse: got coin=%b reject=%b at cycle %0d, expected coin=%b reject=%b at cycle %0d",
                   coin, reject, cyc, e.code, e.rej, e.at);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests        = 0;
    failures     = 0;
    reset        = 1'b1;
    nickel_sense = 1'b0;
    dime_sense   = 1'b0;
    inhibit      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_coin", int'(coin), 0);
    checkOutput("rst_reject", int'(reject), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_nickel_count", int'(nickel_count), 0);
    checkOutput("rst_dime_count", int'(dime_count), 0);
    reset = 1'b0;
    @(negedge clk);

    // Plain nickel, held 10 cycles
    applyStimulus(1'b1, 1'b0, 10, 1'b0, 2'b01, 1'b0, 5);
    checkOutput("t1_nickel_count", int'(nickel_count), 1);

    // Two-cycle dime glitch is dropped silently
    applyStimulus(1'b0, 1'b1, 2, 1'b0, 2'b00, 1'b0, 0);
    checkOutput("t2_dime_count", int'(dime_count), 0);
    checkOutput("t2_nickel_count", int'(nickel_count), 1);

    // Both lines together
    applyStimulus(1'b1, 1'b1, 8, 1'b0, 2'b00, 1'b1, 2);
    checkOutput("t3_nickel_count", int'(nickel_count), 1);
    checkOutput("t3_dime_count", int'(dime_count), 0);

    // Dime under inhibit, then dime without
    applyStimulus(1'b0, 1'b1, 8, 1'b1, 2'b00, 1'b1, 5);
    checkOutput("t4_dime_inhibited", int'(dime_count), 0);
    applyStimulus(1'b0, 1'b1, 8, 1'b0, 2'b10, 1'b0, 5);
    checkOutput("t4_dime_count", int'(dime_count), 1);

    // Walk nickel_count up to 253, then 3 more must saturate at 255
    for (int i = 0; i < 252; i++) applyStimulus(1'b1, 1'b0, 6, 1'b0, 2'b01, 1'b0, 5);
    checkOutput("t5_nickel_253", int'(nickel_count), 253);
    applyStimulus(1'b1, 1'b0, 6, 1'b0, 2'b01, 1'b0, 5);
    checkOutput("t5_nickel_254", int'(nickel_count), 254);
    applyStimulus(1'b1, 1'b0, 6, 1'b0, 2'b01, 1'b0, 5);
    checkOutput("t5_nickel_255", int'(nickel_count), 255);
    applyStimulus(1'b1, 1'b0, 6, 1'b0, 2'b01, 1'b0, 5);
    checkOutput("t5_nickel_sat", int'(nickel_count), 255);
    applyStimulus(1'b1, 1'b0, 50, 1'b0, 2'b01, 1'b0, 5);
    checkOutput("t5_held_single", int'(nickel_count), 255);
    checkOutput("t5_dime_kept", int'(dime_count), 1);

    // Reset while qualifying a nickel
    nickel_sense = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t6_busy_before", int'(busy), 1);
    reset        = 1'b1;
    nickel_sense = 1'b0;
    @(negedge clk);
    checkOutput("t6_coin", int'(coin), 0);
    checkOutput("t6_busy", int'(busy), 0);
    checkOutput("t6_nickel_count", int'(nickel_count), 0);
    checkOutput("t6_dime_count", int'(dime_count), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("t6_busy_after", int'(busy), 0);

    checkOutput("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
